// File: rtl/positadd_arbiter.sv
// positadd_arbiter: shares one pipelined 32-bit posit adder between NREQ
// requesters. Round-robin grant, one issue per cycle, tag carried through a
// shadow pipeline matching the adder latency, results collected in a
// first-word-fall-through response FIFO. Issues are credit-limited so the
// FIFO cannot overflow.
// Optional feature macro: POSITADD_ARB_STATS_EN adds issue_cnt, a set of
// per-requester saturating 16-bit issue counters.
//
// Handshake: a transfer happens on a requester port in any cycle where
// req_valid[i] & req_ready[i]; on the response port when rsp_valid & rsp_ready.
// req_ready is combinational from req_valid, so requesters must not derive
// req_valid from req_ready. rsp_valid never depends on rsp_ready.
module positadd_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADD_LAT    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*32-1:0]       req_in1,
  input  logic [NREQ*32-1:0]       req_in2,
  output logic [31:0]              add_in1,
  output logic [31:0]              add_in2,
  output logic                     add_start,
  input  logic [31:0]              add_result,
  input  logic                     add_inf,
  input  logic                     add_zero,
  input  logic                     add_done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_result,
  output logic                     rsp_inf,
  output logic                     rsp_zero,
  output logic [$clog2(NREQ)-1:0]  rsp_tag,
  output logic                     busy,
  output logic                     err
`ifdef POSITADD_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]       issue_cnt
`endif
);

  localparam int TAGW = $clog2(NREQ);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int LW   = $clog2(ADD_LAT + 1);
  localparam int EW   = 32 + 2 + TAGW;

  // Arbitration state
  logic [TAGW-1:0] ptr;
  logic [TAGW-1:0] grant_idx;
  logic [TAGW-1:0] cand;
  logic            found;
  logic            issue;
  logic            issue_ok;
  logic [CW:0]     credit_used;

  // Shadow pipeline
  logic            sh_v   [ADD_LAT];
  logic [TAGW-1:0] sh_tag [ADD_LAT];
  logic [LW-1:0]   inflight;
  logic            push;

  // Response FIFO
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic            pop;

  // Count valid shadow stages; this equals the number of ops still in the adder
  always_comb begin
    inflight = '0;
    for (int s = 0; s < ADD_LAT; s++) begin
      inflight = inflight + LW'(sh_v[s]);
    end
  end

  // Credits: registered occupancy only, so a same-cycle pop frees nothing yet
  always_comb begin
    credit_used = {1'b0, fifo_count} + (CW+1)'(inflight);
    issue_ok    = credit_used < (CW+1)'(FIFO_DEPTH);
  end

  // Round-robin search from ptr upward with wrap; first valid requester wins
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = TAGW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Issue side: operands are zeroed when nothing is issued
  always_comb begin
    issue     = found & issue_ok;
    req_ready = '0;
    add_start = issue;
    add_in1   = '0;
    add_in2   = '0;
    if (issue) begin
      req_ready[grant_idx] = 1'b1;
      add_in1              = req_in1[32*grant_idx +: 32];
      add_in2              = req_in2[32*grant_idx +: 32];
    end
  end

  // Round-robin pointer advances past the requester just served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (grant_idx == TAGW'(NREQ-1)) ? '0 : grant_idx + TAGW'(1);
    end
  end

  // Shadow pipeline of {valid, tag}, one stage per adder cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < ADD_LAT; s++) begin
        sh_v[s]   <= 1'b0;
        sh_tag[s] <= '0;
      end
    end else begin
      sh_v[0]   <= issue;
      sh_tag[0] <= grant_idx;
      for (int s = 1; s < ADD_LAT; s++) begin
        sh_v[s]   <= sh_v[s-1];
        sh_tag[s] <= sh_tag[s-1];
      end
    end
  end

  // Capture follows the tail valid bit; add_done is only cross-checked
  assign push = sh_v[ADD_LAT-1];

  // Sticky error when the adder's done disagrees with the shadow tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (add_done != push) begin
      err <= 1'b1;
    end
  end

  // Response FIFO: FWFT head, power-of-two depth so pointers wrap naturally
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign {rsp_tag, rsp_inf, rsp_zero, rsp_result} = mem[rd_ptr];

  // FIFO storage and pointers; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        mem[e] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {sh_tag[ADD_LAT-1], add_inf, add_zero, add_result};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign busy = (inflight != '0) | (fifo_count != '0);

  // The credit rule makes a push into a full FIFO unreachable
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifo_count == CW'(FIFO_DEPTH))));

`ifdef POSITADD_ARB_STATS_EN
  // Per-requester issue counters, saturating at 0xFFFF
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (issue && (grant_idx == TAGW'(i)) && (issue_cnt[16*i +: 16] != 16'hFFFF)) begin
          issue_cnt[16*i +: 16] <= issue_cnt[16*i +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_positadd_arbiter.sv
// tb_positadd_arbiter: drives positadd_arbiter with a stand-in pipelined
// adder and checks every issue and response against a transaction-level model
// (round-robin pointer, outstanding-op credit count, in-order response queue).
// Define POSITADD_ARB_STATS_EN to also check the issue counters.
module tb_positadd_arbiter;
  localparam int NREQ       = 4;
  localparam int ADD_LAT    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int TAGW       = 2;
  localparam int W          = 32 + TAGW + 2 + 32;

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_in1, req_in2;
  logic [31:0]       add_in1, add_in2, add_result;
  logic              add_start, add_inf, add_zero, add_done;
  logic              rsp_valid, rsp_ready, rsp_inf, rsp_zero, busy, err;
  logic [31:0]       rsp_result;
  logic [TAGW-1:0]   rsp_tag;
`ifdef POSITADD_ARB_STATS_EN
  logic [NREQ*16-1:0] issue_cnt;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_in1[32*gi +: 32] = op_a[gi];
    assign req_in2[32*gi +: 32] = op_b[gi];
  end

  positadd_arbiter #(.NREQ(NREQ), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .busy(busy), .err(err)
`ifdef POSITADD_ARB_STATS_EN
    , .issue_cnt(issue_cnt)
`endif
  );

  // ---------------- counters / check ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stand-in adder ----------------
  // Known posit cases are exact (NaR absorbs, x + -x = 0 since posit negation
  // is two's complement, 1.0 + 1.0 = 2.0); anything else maps to an
  // order-sensitive scramble, since the arbiter never interprets data.
  function automatic logic [31:0] core_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    if (a == 32'h8000_0000 || b == 32'h8000_0000) return 32'h8000_0000;
    if (s == 32'h0) return 32'h0;
    if (a == 32'h0) return b;
    if (b == 32'h0) return a;
    if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
    return a ^ {b[30:0], b[31]} ^ 32'h0000_0001;
  endfunction

  logic        pv [ADD_LAT];
  logic [31:0] pr [ADD_LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < ADD_LAT; s++) pv[s] <= 1'b0;
    end else begin
      pv[0] <= add_start;
      pr[0] <= core_add(add_in1, add_in2);
      for (int s = 1; s < ADD_LAT; s++) begin
        pv[s] <= pv[s-1];
        pr[s] <= pr[s-1];
      end
    end
  end

  assign add_done   = pv[ADD_LAT-1];
  assign add_result = pv[ADD_LAT-1] ? pr[ADD_LAT-1] : 32'hDEAD_BEEF;
  assign add_inf    = pv[ADD_LAT-1] ? (pr[ADD_LAT-1] == 32'h8000_0000) : 1'b1;
  assign add_zero   = pv[ADD_LAT-1] ? (pr[ADD_LAT-1] == 32'h0) : 1'b1;

  // ---------------- scoreboard / monitor ----------------
  // exp_q entry: {available cycle, tag, inf, zero, result}
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    head;
  logic [NREQ-1:0] fired;
  logic [NREQ-1:0] m_ready;
  logic [31:0]     m_res;
  logic            m_ev;
  int              m_g;
  int              outstanding;
  int              ref_ptr;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      outstanding = 0;
      ref_ptr     = 0;
      fired       = '0;
    end else begin
      m_ready = '0;
      m_g     = -1;
      if (outstanding < FIFO_DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          if (m_g < 0 && req_valid[(ref_ptr + k) % NREQ]) m_g = (ref_ptr + k) % NREQ;
        end
      end
      if (m_g >= 0) m_ready[m_g] = 1'b1;
      m_ev = (exp_q.size() > 0) && (exp_q[0][W-1 -: 32] <= 32'(cyc));

      check("req_ready", req_ready, m_ready);
      check("add_start", add_start, m_g >= 0);
      check("add_in1", add_in1, (m_g >= 0) ? op_a[m_g] : 32'h0);
      check("add_in2", add_in2, (m_g >= 0) ? op_b[m_g] : 32'h0);
      check("rsp_valid", rsp_valid, m_ev);
      check("busy", busy, outstanding != 0);
      check("err", err, 1'b0);

      if (m_ev && rsp_ready) begin
        head = exp_q.pop_front();
        check("rsp_data", {rsp_tag, rsp_inf, rsp_zero, rsp_result}, head[TAGW+33:0]);
        outstanding--;
      end
      if (m_g >= 0) begin
        m_res = core_add(op_a[m_g], op_b[m_g]);
        exp_q.push_back({32'(cyc + ADD_LAT + 1), TAGW'(m_g),
                         m_res == 32'h8000_0000, m_res == 32'h0, m_res});
        outstanding++;
        ref_ptr = (m_g + 1) % NREQ;
      end
      fired = req_valid & req_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h4000_0000;
      1:       return 32'hC000_0000;
      2:       return 32'h8000_0000;
      3:       return 32'h0;
      default: return $urandom();
    endcase
  endfunction

  task automatic issue_one(input int i, input logic [31:0] a, input logic [31:0] b, output int c);
    step();
    req_valid = '0;
    op_a[i] = a;
    op_b[i] = b;
    req_valid[i] = 1'b1;
    c = -1;
    for (int n = 0; n < 20 && c < 0; n++) begin
      @(negedge clk);
      if (req_ready[i]) c = cyc;
      else step();
    end
    if (c < 0) check("issue_timeout", 0, 1);
    step();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input string nm, input int c, input logic [31:0] res,
                          input logic zero, input logic [TAGW-1:0] tag);
    int seen = -1;
    logic [31:0] r_res = '0;
    logic r_zero = 1'b0;
    logic [TAGW-1:0] r_tag = '0;
    for (int n = 0; n < 15 && seen < 0; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = cyc; r_res = rsp_result; r_zero = rsp_zero; r_tag = rsp_tag;
      end
    end
    check({nm, "_latency"}, seen - c, ADD_LAT + 1);
    check({nm, "_result"}, r_res, res);
    check({nm, "_zero"}, r_zero, zero);
    check({nm, "_tag"}, r_tag, tag);
  endtask

  task automatic drain();
    int n = 0;
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    step();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int n_iss;
    int extra;
    int first;
    int p;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_add_start", add_start, 0);
    check("rst_add_in1", add_in1, 0);
    check("rst_add_in2", add_in2, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // T1: 1.0 + 1.0 from requester 0
    issue_one(0, 32'h4000_0000, 32'h4000_0000, c);
    wait_rsp("t1", c, 32'h4800_0000, 1'b0, 2'd0);

    // T3: 1.0 + -1.0 from requester 2
    issue_one(2, 32'h4000_0000, 32'hC000_0000, c);
    wait_rsp("t3", c, 32'h0, 1'b1, 2'd2);
    drain();

    // T4: credit exhaustion with the consumer stalled
    rsp_ready = 1'b0;
    op_a[1] = rand_op();
    op_b[1] = rand_op();
    req_valid[1] = 1'b1;
    n_iss = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (req_ready[1]) n_iss++;
      step();
    end
    check("t4_issues", n_iss, FIFO_DEPTH);
    rsp_ready = 1'b1;
    p = cyc;
    extra = 0;
    first = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        extra++;
        if (first < 0) first = cyc;
      end
      step();
      rsp_ready = 1'b0;
    end
    check("t4_extra_issues", extra, 1);
    check("t4_extra_cycle", first, p + 1);
    drain();

    // T5: reset with three ops in flight
    step();
    req_valid = 4'b0111;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = rand_op(); op_b[i] = rand_op(); end
    repeat (3) step();
    req_valid = '0;
    @(negedge clk);
    check("t5_busy_before", busy, 1'b1);
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t5_rsp_valid", rsp_valid, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_err", err, 1'b0);
    end

    // T2: all requesters held valid, grants rotate from requester 0
    step();
    req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t2_grant", req_ready, 4'b0001 << (k % NREQ));
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (fired[i]) begin op_a[i] = rand_op(); op_b[i] = rand_op(); end
      end
    end
    drain();

    // Randomized traffic with random consumer back-pressure
    for (int k = 0; k < 400; k++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || fired[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 45);
          op_a[i] = rand_op();
          op_b[i] = rand_op();
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
    end
    drain();

    // T6: issue counting after a fresh reset
    pulse_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) issue_one(3, rand_op(), rand_op(), c);
    for (int k = 0; k < 2; k++) issue_one(0, rand_op(), rand_op(), c);
    drain();
`ifdef POSITADD_ARB_STATS_EN
    @(negedge clk);
    check("t6_issue_cnt", issue_cnt, {16'd5, 16'd0, 16'd0, 16'd2});
`endif

    repeat (3) @(negedge clk);
    check("end_busy", busy, 1'b0);
    check("end_err", err, 1'b0);
    check("end_rsp_valid", rsp_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Time bound on the whole run
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
